// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared byte width, CR/LF characters and feeder FSM encoding
package uart_pkg;

  localparam int BYTE_W = 8;

  localparam logic [BYTE_W-1:0] CHAR_CR = 8'h0D;
  localparam logic [BYTE_W-1:0] CHAR_LF = 8'h0A;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LOAD      = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/byte_fifo.sv
// rtl/byte_fifo.sv - circular byte FIFO with entry count and sticky overflow flag
module byte_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     wr_en,
  input  logic [BYTE_W-1:0]        wr_data,
  input  logic                     rd_en,
  output logic [BYTE_W-1:0]        rd_data,
  input  logic                     ovf_clr,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     overflow
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [BYTE_W-1:0] mem_q [DEPTH];
  logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
  logic [AW:0]       count_q, count_d;
  logic              ovf_q, ovf_d;
  logic              do_wr, do_rd;

  assign full     = (count_q == FULL_CNT);
  assign empty    = (count_q == '0);
  assign level    = count_q;
  assign overflow = ovf_q;
  assign rd_data  = mem_q[rd_ptr_q];

  // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
  assign do_rd = rd_en && !empty;
  assign do_wr = wr_en && (!full || do_rd);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    ovf_d    = ovf_q;
    if (do_wr) wr_ptr_d = wr_ptr_q + 1'b1;
    if (do_rd) rd_ptr_d = rd_ptr_q + 1'b1;
    case ({do_wr, do_rd})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
    if (ovf_clr) begin
      ovf_d = 1'b0;
    end else if (wr_en && !do_wr) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/uart_tx_feeder.sv
// rtl/uart_tx_feeder.sv - FIFO-buffered byte feeder handshaking with a UART transmitter
// Optional CRLF_EXPAND_EN: a queued LF is sent as CR then LF, consuming one FIFO entry.
module uart_tx_feeder
  import uart_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int GUARD = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   wr_en,
  input  logic [BYTE_W-1:0]      wr_data,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level,
  output logic                   overflow,
  input  logic                   ovf_clr,
  output logic                   tx_transmit,
  output logic [BYTE_W-1:0]      tx_byte,
  input  logic                   tx_busy
);

  localparam int GW = (GUARD > 1) ? $clog2(GUARD) : 1;
  localparam logic [GW-1:0] GUARD_LAST = GW'(GUARD - 1);

  tx_state_e         state_q, state_d;
  logic [GW-1:0]     guard_q, guard_d;
  logic              tx_transmit_q, tx_transmit_d;
  logic [BYTE_W-1:0] tx_byte_q, tx_byte_d;
  logic              fifo_rd;
  logic [BYTE_W-1:0] fifo_rd_data;
  logic              fifo_empty;
  logic              have_byte;

  byte_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_data  (wr_data),
    .rd_en    (fifo_rd),
    .rd_data  (fifo_rd_data),
    .ovf_clr  (ovf_clr),
    .full     (full),
    .empty    (fifo_empty),
    .level    (level),
    .overflow (overflow)
  );

  assign empty       = fifo_empty;
  assign tx_transmit = tx_transmit_q;
  assign tx_byte     = tx_byte_q;

`ifdef CRLF_EXPAND_EN
  logic lf_pend_q, lf_pend_d;

  assign have_byte = !fifo_empty || lf_pend_q;
`else
  assign have_byte = !fifo_empty;
`endif

  always_comb begin
    state_d       = state_q;
    guard_d       = guard_q;
    tx_transmit_d = 1'b0;
    tx_byte_d     = tx_byte_q;
    fifo_rd       = 1'b0;
`ifdef CRLF_EXPAND_EN
    lf_pend_d     = lf_pend_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (have_byte && !tx_busy) state_d = ST_LOAD;
      end
      // Busy is re-checked here so the load pulse never overlaps an active transmission.
      ST_LOAD: begin
        if (!tx_busy) begin
          tx_transmit_d = 1'b1;
          guard_d       = '0;
          state_d       = ST_WAIT_BUSY;
`ifdef CRLF_EXPAND_EN
          if (lf_pend_q) begin
            tx_byte_d = CHAR_LF;
            lf_pend_d = 1'b0;
          end else begin
            fifo_rd = 1'b1;
            if (fifo_rd_data == CHAR_LF) begin
              tx_byte_d = CHAR_CR;
              lf_pend_d = 1'b1;
            end else begin
              tx_byte_d = fifo_rd_data;
            end
          end
`else
          fifo_rd   = 1'b1;
          tx_byte_d = fifo_rd_data;
`endif
        end
      end
      // A transmitter that never acknowledges is assumed to have taken the byte.
      ST_WAIT_BUSY: begin
        if (tx_busy) begin
          state_d = ST_WAIT_DONE;
        end else if (guard_q == GUARD_LAST) begin
          state_d = ST_IDLE;
        end else begin
          guard_d = guard_q + 1'b1;
        end
      end
      ST_WAIT_DONE: begin
        if (!tx_busy) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      guard_q       <= '0;
      tx_transmit_q <= 1'b0;
      tx_byte_q     <= '0;
    end else begin
      state_q       <= state_d;
      guard_q       <= guard_d;
      tx_transmit_q <= tx_transmit_d;
      tx_byte_q     <= tx_byte_d;
    end
  end

`ifdef CRLF_EXPAND_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lf_pend_q <= 1'b0;
    end else begin
      lf_pend_q <= lf_pend_d;
    end
  end
`endif

endmodule

// File: tb/tb_uart_tx_feeder.sv
// tb/tb_uart_tx_feeder.sv - scoreboard bench for uart_tx_feeder with a behavioural UART model
module tb_uart_tx_feeder;

  localparam int DEPTH = 16;
  localparam int GUARD = 3;
  localparam int LW    = $clog2(DEPTH) + 1;

  typedef struct {
    logic [7:0] data;
    bit         entry;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          wr_en = 1'b0;
  logic [7:0]    wr_data = 8'h00;
  logic          ovf_clr = 1'b0;
  logic          tx_busy = 1'b0;
  logic          full, empty, overflow, tx_transmit;
  logic [LW-1:0] level;
  logic [7:0]    tx_byte;

  int compared = 0;
  int mismatched = 0;
  int cyc = 0;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         pulse_cyc[$];
  int         accepted = 0;
  int         entries_sent = 0;
  bit         ovf_m = 1'b0;
  logic [7:0] last_byte = 8'h00;
  int         push_cyc = 0;

  bit force_busy = 1'b0;
  bit rand_uart = 1'b0;
  bit rise_en = 1'b1;
  int pend = -1;
  int busy_left = 0;
  int blen = 0;

  uart_tx_feeder #(
    .DEPTH(DEPTH),
    .GUARD(GUARD)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .wr_en       (wr_en),
    .wr_data     (wr_data),
    .full        (full),
    .empty       (empty),
    .level       (level),
    .overflow    (overflow),
    .ovf_clr     (ovf_clr),
    .tx_transmit (tx_transmit),
    .tx_byte     (tx_byte),
    .tx_busy     (tx_busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    compared++;
    if (act !== expv) begin
      mismatched++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, expv, cyc);
    end
  endtask

  // Reference model: each accepted push becomes one or two expected pulses.
  task automatic model_push(input logic [7:0] d);
    exp_t e;
    accepted++;
`ifdef CRLF_EXPAND_EN
    if (d == 8'h0A) begin
      e.data = 8'h0D; e.entry = 1'b1; exp_q.push_back(e);
      e.data = 8'h0A; e.entry = 1'b0; exp_q.push_back(e);
      return;
    end
`endif
    e.data = d; e.entry = 1'b1; exp_q.push_back(e);
  endtask

  // Monitor and UART model, both evaluated on the falling edge.
  always @(negedge clk) begin
    if (!rst_n) begin
      entries_sent = 0;
      last_byte    = 8'h00;
      pend         = -1;
      busy_left    = 0;
      tx_busy      = 1'b0;
    end else begin
      if (tx_transmit) begin
        chk("no_pulse_while_busy", tx_busy, 0);
        if (exp_q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL spurious_pulse: got pulse with byte 0x%0h, expected no pulse", tx_byte);
        end else begin
          mon_e = exp_q.pop_front();
          chk("tx_byte", tx_byte, mon_e.data);
          if (mon_e.entry) entries_sent++;
        end
        last_byte = tx_byte;
        pulse_cyc.push_back(cyc);
      end else begin
        chk("tx_byte_hold", tx_byte, last_byte);
      end
      chk("level", level, accepted - entries_sent);
      chk("empty", empty, accepted == entries_sent);
      chk("full", full, (accepted - entries_sent) == DEPTH);
      chk("overflow", overflow, ovf_m);

      if (force_busy) begin
        tx_busy = 1'b1;
      end else begin
        if (busy_left > 0) busy_left--;
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            busy_left = blen;
            pend = -1;
          end
        end
        if (tx_transmit) begin
          if (rand_uart) begin
            if ($urandom_range(0, 4) != 0) begin
              pend = $urandom_range(1, 2);
              blen = $urandom_range(1, 12);
            end
          end else if (rise_en) begin
            pend = 1;
            blen = 10;
          end
        end
        tx_busy = (busy_left > 0);
      end
    end
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  task automatic push(input logic [7:0] d, input bit acc, input bit clr);
    wr_en = 1'b1;
    wr_data = d;
    ovf_clr = clr;
    @(posedge clk);
    if (acc) model_push(d);
    if (clr) ovf_m = 1'b0;
    else if (!acc) ovf_m = 1'b1;
    #2;
    push_cyc = cyc;
    wr_en = 1'b0;
    ovf_clr = 1'b0;
  endtask

  task automatic clear_ovf();
    ovf_clr = 1'b1;
    @(posedge clk);
    ovf_m = 1'b0;
    #2;
    ovf_clr = 1'b0;
  endtask

  task automatic apply_reset(input int n);
    rst_n = 1'b0;
    exp_q.delete();
    accepted = 0;
    ovf_m = 1'b0;
    step(n);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_level", level, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_tx_transmit", tx_transmit, 0);
    chk("rst_tx_byte", tx_byte, 8'h00);
    rst_n = 1'b1;
  endtask

  task automatic wait_pulses(input int k, input int budget);
    int n;
    n = 0;
    while (pulse_cyc.size() < k && n < budget) begin
      step(1);
      n++;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while ((exp_q.size() != 0 || tx_busy) && n < 3000) begin
      step(1);
      n++;
    end
    chk(name, exp_q.size(), 0);
    step(20);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [7:0] rb;
    int gap;

    apply_reset(3);
    step(2);

    // Single byte, idle UART: two-cycle latency to the load pulse.
    pulse_cyc.delete();
    push(8'h41, 1, 0);
    gap = push_cyc;
    wait_pulses(1, 50);
    chk("first_latency", (pulse_cyc.size() > 0) ? pulse_cyc[0] - gap : -1, 2);
    wait_drain("drain_41");
    chk("level_after_41", level, 0);

    // Fill with the UART busy, then overflow and clear behaviour.
    force_busy = 1'b1;
    step(2);
    for (int i = 1; i <= 16; i++) push(8'(i), 1, 0);
    chk("full_at_16", full, 1);
    chk("level_at_16", level, 16);
    push(8'h11, 0, 0);
    chk("ovf_after_drop", overflow, 1);
    push(8'h22, 0, 1);
    chk("ovf_clr_priority", overflow, 0);
    push(8'h23, 0, 0);
    clear_ovf();
    chk("ovf_cleared", overflow, 0);

    // Release busy so the first pop coincides with a push into the full FIFO.
    force_busy = 1'b0;
    step(1);
    push(8'h99, 1, 0);
    chk("level_push_pop_full", level, 16);
    chk("ovf_push_pop_full", overflow, 0);
    wait_drain("drain_burst");

    // Transmitter never acknowledges: guard timeout then the next load.
    rise_en = 1'b0;
    pulse_cyc.delete();
    push(8'h31, 1, 0);
    push(8'h32, 1, 0);
    wait_pulses(2, 100);
    chk("guard_gap", (pulse_cyc.size() >= 2) ? pulse_cyc[1] - pulse_cyc[0] : -1, GUARD + 2);
    wait_drain("drain_guard");
    rise_en = 1'b1;

    // Line feed handling.
    pulse_cyc.delete();
    push(8'h0A, 1, 0);
    wait_drain("drain_lf");
`ifdef CRLF_EXPAND_EN
    chk("lf_pulse_count", pulse_cyc.size(), 2);
`else
    chk("lf_pulse_count", pulse_cyc.size(), 1);
`endif

    // Reset while waiting for the transmitter with five bytes still queued.
    for (int i = 0; i < 6; i++) push(8'h61 + 8'(i), 1, 0);
    step(6);
    chk("queued_before_reset", level, 5);
    chk("busy_before_reset", tx_busy, 1);
    apply_reset(2);
    pulse_cyc.delete();
    step(30);
    chk("no_pulse_after_reset", pulse_cyc.size(), 0);
    push(8'h5A, 1, 0);
    wait_drain("drain_after_reset");

    // Randomised traffic against a randomised transmitter.
    rand_uart = 1'b1;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 2) == 0 && (accepted - entries_sent) < DEPTH) begin
        rb = 8'($urandom_range(0, 255));
        if ($urandom_range(0, 7) == 0) rb = 8'h0A;
        push(rb, 1, 0);
      end else begin
        step(1);
      end
    end
    wait_drain("drain_random");
    chk("level_final", level, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/uart_tx_feeder.md
UART_TX_FEEDER -- requirements
Module: uart_tx_feeder

Interface
REQ-001 SHALL have parameter DEPTH, default 16, FIFO entries; power of two, range 2..256.
REQ-002 SHALL have parameter GUARD, default 3, cycles to wait for tx_busy to rise after a load.
REQ-003 SHALL have port clk  in  1  single clock; all state on posedge clk.
REQ-004 SHALL have port rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005 SHALL have port wr_en  in  1  push strobe, one byte per cycle.
REQ-006 SHALL have port wr_data  in  8  byte to push.
REQ-007 SHALL have port full  out  1  FIFO holds DEPTH entries.
REQ-008 SHALL have port empty  out  1  FIFO holds 0 entries.
REQ-009 SHALL have port level  out  $clog2(DEPTH)+1  current entry count.
REQ-010 SHALL have port overflow  out  1  sticky flag for a dropped push.
REQ-011 SHALL have port ovf_clr  in  1  clears overflow.
REQ-012 SHALL have port tx_transmit  out  1  one-cycle load pulse to the UART transmitter.
REQ-013 SHALL have port tx_byte  out  8  byte presented to the UART; stable from the pulse until the next load.
REQ-014 SHALL have port tx_busy  in  1  transmitter is_transmitting.

Function
REQ-015 SHALL implement a circular FIFO with read/write pointers wrapping modulo DEPTH; level = writes - reads.
REQ-016 SHALL accept a push when not full, or when full and a pop occurs in the same cycle.
REQ-017 SHALL drop a push into a full FIFO with no concurrent pop, set overflow the next cycle, and leave FIFO contents unchanged.
REQ-018 SHALL give ovf_clr priority over a simultaneous overflow event (flag ends at 0).
REQ-019 SHALL run an FSM with states IDLE, LOAD, WAIT_BUSY and WAIT_DONE.
REQ-020 SHALL move IDLE->LOAD when not empty and tx_busy=0.
REQ-021 SHALL, in LOAD, pop one entry into tx_byte, assert tx_transmit for exactly one cycle, then enter WAIT_BUSY.
REQ-022 SHALL move WAIT_BUSY->WAIT_DONE on tx_busy=1; if GUARD cycles elapse without it, SHALL return to IDLE with the byte considered sent.
REQ-023 SHALL move WAIT_DONE->IDLE on tx_busy=0.
REQ-024 SHALL have latency from a push into an empty FIFO with idle UART to tx_transmit of 2 cycles.
REQ-025 SHALL never assert tx_transmit while tx_busy=1 or outside LOAD.
REQ-026 SHALL use a push into an empty FIFO in the same cycle as the IDLE check only from the following cycle, with no write-through bypass.

Reset
REQ-027 SHALL on rst_n=0: state IDLE; pointers 0; level 0; empty 1; full 0; overflow 0; tx_transmit 0; tx_byte 8'h00; guard counter 0.
REQ-028 SHALL discard queued bytes on reset mid-transfer; it SHALL NOT issue a further tx_transmit until a new push occurs after reset release.

Configuration
REQ-029 SHALL, with CRLF_EXPAND_EN defined, send 8'h0D and then 8'h0A as two back-to-back full handshakes when a popped byte equals 8'h0A, counting as one FIFO entry; level SHALL decrement once, at the 8'h0D load.
REQ-030 SHALL, without CRLF_EXPAND_EN, send 8'h0A unmodified, with no extra state or logic present.

Structure
REQ-031 SHALL take the FSM state enum, byte width constant 8 and CR/LF constants from shared package uart_pkg.
REQ-032 SHALL place FIFO storage and pointers in sub-module byte_fifo (parameter DEPTH), with the FSM in uart_tx_feeder.

Verification
REQ-033 SHALL cover: push 8'h41 with idle UART model (busy 1 cycle after pulse, 10 cycles long) -> tx_transmit 2 cycles later, tx_byte=8'h41, level returns to 0.
REQ-034 SHALL cover: push 8'h01..8'h10 in 16 consecutive cycles with tx_busy held 1 -> full=1, level=16; a 17th push sets overflow=1; release busy -> 8'h01..8'h10 emitted in order.
REQ-035 SHALL cover: full FIFO, push and pop in the same cycle -> push accepted, level stays 16, overflow stays 0.
REQ-036 SHALL cover: tx_busy never rises after a pulse -> FSM returns to IDLE after 3 cycles and the next byte is loaded.
REQ-037 SHALL cover: with CRLF_EXPAND_EN, push 8'h0A -> two pulses with tx_byte 8'h0D then 8'h0A; without the macro -> one pulse with 8'h0A.
REQ-038 SHALL cover: rst_n low during WAIT_DONE with 5 bytes queued -> empty=1 and no pulse after release until a new push.
